// File: rtl/regfile_mp.sv
// Multi-port register file: flop array, registered reads with write-first bypass,
// optional hardwired-zero r0, and a background clear sweep.
module regfile_mp_rd #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int ZERO_R0 = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              wr_acc,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              sweep,
  input  logic [ADDR_W-1:0] clr_ptr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  // Priority: hardwired zero, then same-edge write, then same-edge clear, then array.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_en;
    if (rd_en) begin
      if (ZERO_R0 != 0 && rd_addr == '0)             rd_data_d = '0;
      else if (wr_acc && wr_addr == rd_addr)         rd_data_d = wr_data;
      else if (sweep && clr_ptr == rd_addr)          rd_data_d = '0;
      else                                           rd_data_d = mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
endmodule

module regfile_mp #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_RD  = 2,
  parameter int ZERO_R0 = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_valid,
  input  logic                       clr_req,
  output logic                       clr_busy,
  output logic                       clr_done
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]                    state_q, state_d;
  logic [ADDR_W-1:0]             ptr_q, ptr_d;
  logic [DEPTH-1:0][DATA_W-1:0]  mem_q, mem_d;
  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr_v;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data_v;
  logic                          sweep, wr_acc;

  assign sweep  = (state_q == S_SWEEP);
  assign wr_acc = wr_en && !sweep && !(ZERO_R0 != 0 && wr_addr == '0);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE:  if (clr_req) begin
                 state_d = S_SWEEP;
                 ptr_d   = '0;
               end
      S_SWEEP: begin
                 ptr_d = ptr_q + ADDR_W'(1);
                 if (ptr_q == '1) state_d = S_DONE;
               end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The sweep owns the single write port while it runs; external writes are dropped.
  always_comb begin
    mem_d = mem_q;
    if (sweep)       mem_d[ptr_q]   = '0;
    else if (wr_acc) mem_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      mem_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mem_q   <= mem_d;
    end
  end

  assign rd_addr_v = rd_addr;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_mp_rd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_R0(ZERO_R0)) u_rd (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_en    (rd_en[k]),
      .rd_addr  (rd_addr_v[k]),
      .mem_rdata(mem_q[rd_addr_v[k]]),
      .wr_acc   (wr_acc),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .sweep    (sweep),
      .clr_ptr  (ptr_q),
      .rd_data  (rd_data_v[k]),
      .rd_valid (rd_valid[k])
    );
  end

  assign rd_data  = rd_data_v;
  assign clr_busy = sweep;
  assign clr_done = (state_q == S_DONE);
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: default 32x32/2-port instance plus a 16-bit, 8-entry, 4-port instance with r0 writable.
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [1:0]  rd_en = '0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic [1:0]  rd_valid;
  logic        clr_req = 1'b0;
  logic        clr_busy, clr_done;

  logic        b_wr_en = 1'b0;
  logic [2:0]  b_wr_addr = '0;
  logic [15:0] b_wr_data = '0;
  logic [3:0]  b_rd_en = '0;
  logic [11:0] b_rd_addr = '0;
  logic [63:0] b_rd_data;
  logic [3:0]  b_rd_valid;
  logic        b_clr_req = 1'b0;
  logic        b_clr_busy, b_clr_done;

  int n_cmp = 0;
  int n_err = 0;
  int busy_cnt, done_cnt;

  always #5 clk = ~clk;

  regfile_mp u0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_R0(0)) u1 (
    .clk(clk), .rst_n(rst_n), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .clr_req(b_clr_req), .clr_busy(b_clr_busy), .clr_done(b_clr_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1);
    rd_en = en; rd_addr = {a1, a0};
    tick();
    rd_en = '0;
  endtask

  initial begin
    #3;
    check("rst_rd_data", rd_data, 64'h0);
    check("rst_rd_valid", {62'h0, rd_valid}, 64'h0);
    check("rst_clr", {62'h0, clr_busy, clr_done}, 64'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Basic write then 1-cycle read, then valid drops while data holds
    wr(5'd5, 32'hDEADBEEF);
    rd(2'b01, 5'd5, 5'd0);
    check("t1_data", {32'h0, rd_data[31:0]}, 64'hDEADBEEF);
    check("t1_valid", {62'h0, rd_valid}, 64'h1);
    tick();
    check("t1_valid_drop", {62'h0, rd_valid}, 64'h0);
    check("t1_data_hold", {32'h0, rd_data[31:0]}, 64'hDEADBEEF);

    // Write-first bypass to both ports
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
    rd(2'b11, 5'd7, 5'd7);
    wr_en = 1'b0;
    check("t2_bypass", rd_data, 64'h12345678_12345678);
    check("t2_valid", {62'h0, rd_valid}, 64'h3);
    rd(2'b11, 5'd5, 5'd7);
    check("t2_mixed", rd_data, 64'h12345678_DEADBEEF);

    // Hardwired r0, including same-edge write+read
    wr(5'd0, 32'hFFFFFFFF);
    rd(2'b11, 5'd0, 5'd0);
    check("t3_r0_read", rd_data, 64'h0);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    rd(2'b11, 5'd0, 5'd5);
    wr_en = 1'b0;
    check("t3_r0_bypass", rd_data, 64'hDEADBEEF_00000000);

    // Fill, then full clear sweep
    for (int i = 1; i < 32; i++) wr(5'(i), 32'h100 + i);
    rd(2'b11, 5'd31, 5'd1);
    check("t4_fill", rd_data, 64'h00000101_0000011F);
    clr_req = 1'b1;
    tick();
    busy_cnt = clr_busy ? 1 : 0;
    done_cnt = 0;
    check("t4_busy_start", {63'h0, clr_busy}, 64'h1);
    for (int c = 1; c <= 40; c++) begin
      clr_req = (c <= 10);
      wr_en   = (c == 20); wr_addr = 5'd3; wr_data = 32'hBAD;
      rd_en   = (c == 5) ? 2'b11 : 2'b00;
      rd_addr = {5'd20, 5'd4};
      tick();
      if (clr_busy) busy_cnt++;
      if (clr_done) done_cnt++;
      if (c == 5) check("t4_clear_bypass", rd_data, 64'h00000114_00000000);
    end
    wr_en = 1'b0; rd_en = '0; clr_req = 1'b0;
    check("t4_busy_cycles", 64'(busy_cnt), 64'd32);
    check("t4_done_pulses", 64'(done_cnt), 64'd1);
    for (int i = 0; i < 32; i++) begin
      rd(2'b11, 5'(i), 5'(31 - i));
      check($sformatf("t4_cleared_r%0d", i), rd_data, 64'h0);
    end
    wr(5'd9, 32'h99);
    rd(2'b01, 5'd9, 5'd0);
    check("t4_write_after", {32'h0, rd_data[31:0]}, 64'h99);

    // Reset in mid-sweep aborts it without a done pulse
    wr(5'd6, 32'h66);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 0; c < 9; c++) tick();
    check("t5_busy_mid", {63'h0, clr_busy}, 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_busy_async", {62'h0, clr_busy, clr_done}, 64'h0);
    check("t5_rd_rst", {rd_data[31:0], 30'h0, rd_valid}, 64'h0);
    #13 rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (clr_done) done_cnt++;
    end
    check("t5_no_done", 64'(done_cnt), 64'd0);
    rd(2'b11, 5'd6, 5'd20);
    check("t5_rd_zero", rd_data, 64'h0);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    check("t5_restart", {63'h0, clr_busy}, 64'h1);
    done_cnt = 0;
    for (int c = 0; c < 40 && done_cnt == 0; c++) begin
      tick();
      if (clr_done) done_cnt++;
    end
    check("t5_restart_done", 64'(done_cnt), 64'd1);

    // Four-port, 16-bit, 8-entry instance with r0 writable
    b_wr_en = 1'b1;
    b_wr_addr = 3'd2; b_wr_data = 16'h00A2; tick();
    b_wr_addr = 3'd3; b_wr_data = 16'h00A3; tick();
    b_wr_addr = 3'd7; b_wr_data = 16'h00A7; tick();
    b_wr_addr = 3'd0; b_wr_data = 16'h00B0; tick();
    b_wr_en = 1'b0;
    b_rd_en = 4'b1111; b_rd_addr = {3'd7, 3'd2, 3'd3, 3'd2};
    tick();
    check("t6_four_ports", b_rd_data, 64'h00A7_00A2_00A3_00A2);
    check("t6_valid", {60'h0, b_rd_valid}, 64'hF);
    b_rd_en = 4'b0001; b_rd_addr = 12'h0;
    tick();
    b_rd_en = 4'b0000;
    check("t6_r0_writable", b_rd_data, 64'h00A7_00A2_00A3_00B0);
    check("t6_valid_one", {60'h0, b_rd_valid}, 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
